// File: rtl/entrada_modos.sv
`default_nettype none
// =============================================================================
// Module      : entrada_modos
// Description : Button front-end for the ALU mode/display path. Synchronises and
//               debounces the selector/start pushbuttons, steps the mode counter,
//               captures operands and drives the run flag / display decoder mode.
// Revision    : 1.0 - initial synchronous release
// =============================================================================
module entrada_modos #(
   parameter int n               = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int NUM_MODOS       = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         selector,
   input  logic         start,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   output logic [3:0]   modo,
   output logic [n-1:0] A_reg,
   output logic [n-1:0] B_reg,
   output logic         flag,
   output logic [1:0]   deco,
   output logic         op_valid
);

   localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] c_cnt_max  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]    c_modo_max = 4'(NUM_MODOS - 1);

   typedef enum logic [0:0] {
      SELECT = 1'b0,
      RUN    = 1'b1
   } state_t;

   // Reset asserts immediately but is released on a clock edge.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   logic [n-1:0] r_a_s1, r_a_s2, r_b_s1, r_b_s2;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_a_s1 <= '0;
         r_a_s2 <= '0;
         r_b_s1 <= '0;
         r_b_s2 <= '0;
      end else begin
         r_a_s1 <= A;
         r_a_s2 <= r_a_s1;
         r_b_s1 <= B;
         r_b_s2 <= r_b_s1;
      end
   end

   // Index 0 = selector, 1 = start; w_press is a one-cycle pulse per press.
   logic [1:0] w_raw;
   logic [1:0] w_press;

   assign w_raw = {start, selector};

   for (genvar i = 0; i < 2; i++) begin : g_btn
      logic          r_s1, r_s2, r_lvl, r_lvl_d;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_lvl   <= 1'b1;
            r_lvl_d <= 1'b1;
            r_cnt   <= '0;
         end else begin
            r_s1    <= w_raw[i];
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            if (r_s2 == r_lvl) begin
               r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
               r_cnt <= '0;
               r_lvl <= ~r_lvl;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign w_press[i] = r_lvl_d & ~r_lvl;
   end

   state_t       r_state, w_state_nxt;
   logic [3:0]   r_modo, w_modo_nxt;
   logic [n-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
   logic         r_ov, r_pend, w_ov_nxt, w_pend_nxt, w_new;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= SELECT;
         r_modo  <= 4'd0;
         r_a     <= '0;
         r_b     <= '0;
         r_ov    <= 1'b0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_modo  <= w_modo_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_ov    <= w_ov_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_modo_nxt  = r_modo;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_new       = 1'b0;

      if (w_press[0])
         w_modo_nxt = (r_modo == c_modo_max) ? 4'd0 : r_modo + 4'd1;

      if (w_press[1]) begin
         w_a_nxt     = r_a_s2;
         w_b_nxt     = r_b_s2;
         w_state_nxt = RUN;
      end

      case (r_state)
         SELECT:  w_new = w_press[1];
         RUN:     w_new = |w_press;
         default: w_new = 1'b0;
      endcase

      // A pulse landing right after another is deferred one cycle, never merged away.
      w_ov_nxt   = (w_new | r_pend) & ~r_ov;
      w_pend_nxt = (w_new | r_pend) & r_ov;
   end

   assign modo     = r_modo;
   assign A_reg    = r_a;
   assign B_reg    = r_b;
   assign flag     = (r_state == RUN);
   assign deco     = {2{flag}};
   assign op_valid = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_entrada_modos.sv
`default_nettype none
// =============================================================================
// Module      : tb_entrada_modos
// Description : Directed self-checking bench for entrada_modos (DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_entrada_modos;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         selector;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [3:0]   modo;
   logic [N-1:0] A_reg;
   logic [N-1:0] B_reg;
   logic         flag;
   logic [1:0]   deco;
   logic         op_valid;

   int n_checks = 0;
   int n_pass   = 0;
   int ov_cnt   = 0;
   bit ov_prev  = 1'b0;
   bit ov_b2b   = 1'b0;

   always #5 clk = ~clk;

   entrada_modos #(
      .n               (N),
      .DEBOUNCE_CYCLES (4),
      .NUM_MODOS       (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .selector (selector),
      .start    (start),
      .A        (A),
      .B        (B),
      .modo     (modo),
      .A_reg    (A_reg),
      .B_reg    (B_reg),
      .flag     (flag),
      .deco     (deco),
      .op_valid (op_valid)
   );

   always @(negedge clk) begin
      if (op_valid) ov_cnt++;
      if (op_valid && ov_prev) ov_b2b = 1'b1;
      ov_prev = op_valid;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Hold the chosen buttons low; returns just after the 6th edge, one before the update.
   task automatic push(input bit ps, input bit pt);
      @(negedge clk);
      if (ps) selector = 1'b0;
      if (pt) start    = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_all();
      @(negedge clk);
      selector = 1'b1;
      start    = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_modo"}, modo, 0);
      check({tag, "_A"}, A_reg, 0);
      check({tag, "_B"}, B_reg, 0);
      check({tag, "_flag"}, flag, 0);
      check({tag, "_deco"}, deco, 0);
      check({tag, "_ov"}, op_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset    = 1'b0;
      selector = 1'b1;
      start    = 1'b1;
      A        = '0;
      B        = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      @(negedge clk) reset = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("rel_no_ov", ov_cnt, 0);

      // Ten clean selector presses in SELECT
      for (int i = 1; i <= 10; i++) begin
         push(1'b1, 1'b0);
         check("sel_early", modo, i - 1);
         tick();
         check("sel_modo", modo, i % 10);
         check("sel_flag", flag, 0);
         check("sel_deco", deco, 0);
         release_all();
      end
      check("sel_no_ov", ov_cnt, 0);

      // Short glitch is rejected
      @(negedge clk) selector = 1'b0;
      @(negedge clk);
      @(negedge clk) selector = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("glitch", modo, 0);

      // Bounce every cycle, then a stable press: one step at the 7th edge
      for (int k = 0; k < 20; k++) @(negedge clk) selector = k[0];
      push(1'b1, 1'b0);
      check("bounce_early", modo, 0);
      tick();
      check("bounce_modo", modo, 1);
      release_all();
      for (int i = 0; i < 9; i++) begin
         push(1'b1, 1'b0);
         tick();
         release_all();
      end
      check("wrap_to_0", modo, 0);

      // Start press captures operands and enters RUN
      A = 4'b0110;
      B = 4'b0011;
      push(1'b0, 1'b1);
      check("st_early_flag", flag, 0);
      tick();
      check("st_A", A_reg, 4'b0110);
      check("st_B", B_reg, 4'b0011);
      check("st_flag", flag, 1);
      check("st_deco", deco, 2'b11);
      check("st_ov", op_valid, 1);
      tick();
      check("st_ov_once", op_valid, 0);
      release_all();
      A = 4'b1111;
      repeat (10) @(posedge clk);
      #1;
      check("hold_A", A_reg, 4'b0110);
      check("ov_cnt_1", ov_cnt, 1);

      // RUN: advance to 9, then wrap with op_valid
      for (int i = 0; i < 9; i++) begin
         push(1'b1, 1'b0);
         tick();
         release_all();
      end
      check("run_modo9", modo, 9);
      check("ov_cnt_10", ov_cnt, 10);
      push(1'b1, 1'b0);
      tick();
      check("run_wrap", modo, 0);
      check("run_flag", flag, 1);
      check("run_sel_ov", op_valid, 1);
      release_all();
      A = 4'b1010;
      push(1'b0, 1'b1);
      tick();
      check("run_A", A_reg, 4'b1010);
      check("run_B", B_reg, 4'b0011);
      check("run_st_ov", op_valid, 1);
      release_all();
      check("ov_cnt_12", ov_cnt, 12);

      // Back to SELECT, modo=3, press both buttons together
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      repeat (4) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         push(1'b1, 1'b0);
         tick();
         release_all();
      end
      check("both_pre_modo", modo, 3);
      check("both_pre_flag", flag, 0);
      push(1'b1, 1'b1);
      tick();
      check("both_modo", modo, 4);
      check("both_flag", flag, 1);
      check("both_deco", deco, 2'b11);
      check("both_A", A_reg, 4'b1010);
      check("both_ov", op_valid, 1);
      tick();
      check("both_ov_once", op_valid, 0);
      release_all();
      check("ov_cnt_13", ov_cnt, 13);

      // Reach modo=7 in RUN, then reset with start mid-debounce
      for (int i = 0; i < 3; i++) begin
         push(1'b1, 1'b0);
         tick();
         release_all();
      end
      check("pre_rst_modo", modo, 7);
      check("ov_cnt_16", ov_cnt, 16);
      @(negedge clk) start = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_reset_vals("async_rst");
      @(negedge clk) start = 1'b1;
      @(negedge clk) reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_ov", ov_cnt, 16);
      check("post_rst_modo", modo, 0);
      check("post_rst_flag", flag, 0);
      push(1'b0, 1'b1);
      tick();
      check("new_press_flag", flag, 1);
      check("new_press_A", A_reg, 4'b1010);
      check("new_press_ov", op_valid, 1);
      release_all();
      check("ov_cnt_17", ov_cnt, 17);
      check("ov_b2b", ov_b2b, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/entrada_modos.md
Name: entrada_modos

Overview:
- Front-end control stage directly upstream of the ALU mode/display datapath on the board.
- Synchronises and debounces the active-low `selector` and `start` pushbuttons, then turns each press into a one-cycle pulse.
- Maintains the mode counter (0..9), captures operands A/B on `start`, and drives the run flag and display-decoder mode consumed downstream.
- Replaces the asynchronous negedge button logic with a single-clock synchronous design.

Parameters:
- `n`, default 4: operand width in bits.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples needed before a button level is accepted (10 ms at 50 MHz).
- `NUM_MODOS`, default 10: number of modes; the counter wraps from NUM_MODOS-1 to 0.

Ports:
- `clk` in 1: system clock; everything is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `selector` in 1: raw pushbutton, active-low, asynchronous to `clk`; a press advances the mode.
- `start` in 1: raw pushbutton, active-low, asynchronous; a press captures operands and enters RUN.
- `A` in n: raw operand switches.
- `B` in n: raw operand switches.
- `modo` out 4: current mode index, 0..NUM_MODOS-1.
- `A_reg` out n: latched operand A.
- `B_reg` out n: latched operand B.
- `flag` out 1: 1 while in RUN (show results), 0 in SELECT (show mode number).
- `deco` out 2: display decoder mode; 2'b00 in SELECT, 2'b11 in RUN.
- `op_valid` out 1: one-cycle pulse when A_reg/B_reg/modo form a new operation.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - `modo`=0, `A_reg`=0, `B_reg`=0, `flag`=0, `deco`=2'b00, `op_valid`=0, FSM=SELECT.
  - Debounced levels set to 1 (released); debounce counters cleared.
  - Release of reset is taken synchronously; no pulse is generated by the release itself.
- Synchroniser: each button passes through a 2-flop synchroniser. A and B are synchronised the same way, per bit.
- Debounce, per button:
  - Counter increments while the synchronised input differs from the debounced level; it clears to 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the level.
- Press pulse: debounced 1->0 transition gives a one-cycle internal pulse. Release (0->1) gives no pulse. A held button gives exactly one pulse.
- Latency: from the raw edge to the pulse is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. Outputs update on the cycle after the pulse.
- FSM states:
  - SELECT:
    - selector pulse: `modo` = (`modo`==NUM_MODOS-1) ? 0 : `modo`+1.
    - start pulse: capture `A_reg`/`B_reg` from synchronised A/B, go to RUN, `flag`=1, `deco`=2'b11, `op_valid`=1 for one cycle.
  - RUN:
    - selector pulse: advance `modo` with the same wrap rule, stay in RUN, pulse `op_valid` (operands unchanged).
    - start pulse: recapture A/B and pulse `op_valid`.
  - RUN exits only via reset.
- Simultaneous pulses in the same cycle: the mode increment and the capture both take effect. `op_valid` fires once, with the new `modo`.
- A and B changing between start presses has no effect on `A_reg`/`B_reg`.
- `op_valid` is never high on two consecutive cycles.
- Reset mid-debounce: the count is discarded and no pulse is produced.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then 9 clean selector presses -> `modo` steps 1..9, `flag`=0, `deco`=00, no `op_valid`. 10th press -> `modo`=0.
- selector low for 2 cycles, then high -> no change in `modo`. Bouncing low/high every cycle for 20 cycles, then held low -> exactly one increment, 7 cycles after the stable low begins.
- `modo`=0, A=4'b0110, B=4'b0011, press start -> next cycle `A_reg`=0110, `B_reg`=0011, `flag`=1, `deco`=11, one-cycle `op_valid`. Then change A to 1111 -> `A_reg` stays 0110.
- In RUN, press selector with `modo`=9 -> `modo`=0, `flag` stays 1, one `op_valid`. Press start with A=1010 -> `A_reg`=1010, one `op_valid`.
- Both buttons pressed on the same clock, `modo`=3 -> `modo`=4, RUN entered, single `op_valid` pulse.
- Assert reset during RUN with `modo`=7 and start mid-debounce -> all outputs are reset values immediately (asynchronous). After release, no pulse until a new full press.
